memory_read_responder: RTL

Responder end of the core's memory read handshake: serves up to NUM_PORTS requesters from a single-port instruction memory with round-robin arbitration. A requester holds valid/addr until it sees ready, then samples the shared data bus. Every completed read is broadcast (address + pulse) so non-granted requesters waiting on the same address can capture the shared data in the same cycle. The memory is loaded by the host through a dedicated write port.

---
 rtl/memory_read_responder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/memory_read_responder.sv
// memory_read_responder
//
// Responder side of the memory read handshake. Up to NUM_PORTS requesters
// share one single-port memory through a round-robin arbiter. A grant is
// followed by a registered memory read and then a one-cycle response in which
// the granted port sees req_ready and every port sees a broadcast of the
// address/data pair, so requesters waiting on the same word can pick it up.
// The host fills the memory through a dedicated write port; a host write
// always wins over arbitration in the cycle it is presented.
//
// Ports
//   clk              clock, all logic on the rising edge
//   rst_n            synchronous active-low reset
//   req_valid        per-port request valid
//   req_addr         per-port address, port i at [i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH]
//   req_ready        per-port completion pulse (one-hot or zero)
//   rd_data          shared read data, holds its last value outside a response
//   broadcast_addr   address of the word on rd_data
//   broadcast_valid  one-cycle pulse per completed read
//   wr_en            host write strobe
//   wr_addr          host write address
//   wr_data          host write data

module memory_read_responder #(
    parameter int MEMORY_ADDR_WIDTH = 10,
    parameter int MEMORY_WIDTH      = 32,
    parameter int NUM_PORTS         = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_PORTS-1:0]                   req_valid,
    input  logic [NUM_PORTS*MEMORY_ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_PORTS-1:0]                   req_ready,
    output logic [MEMORY_WIDTH-1:0]                rd_data,
    output logic [MEMORY_ADDR_WIDTH-1:0]           broadcast_addr,
    output logic                                   broadcast_valid,
    input  logic                                   wr_en,
    input  logic [MEMORY_ADDR_WIDTH-1:0]           wr_addr,
    input  logic [MEMORY_WIDTH-1:0]                wr_data
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int DEPTH = 2 ** MEMORY_ADDR_WIDTH;
    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    // One-hot decode of a port index.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_PORTS-1:0] v;
        for (int i = 0; i < NUM_PORTS; i++) begin
            v[i] = (IDX_W'(i) == idx);
        end
        return v;
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [IDX_W-1:0]        grant_r;
    logic [IDX_W-1:0]        last_grant_r;
    logic [MEMORY_ADDR_WIDTH-1:0] addr_r;
    logic [NUM_PORTS-1:0]    req_ready_r;
    logic                    broadcast_valid_r;
    logic [MEMORY_WIDTH-1:0] rd_data_r;
    logic [MEMORY_ADDR_WIDTH-1:0] broadcast_addr_r;
    logic [MEMORY_WIDTH-1:0] mem_r [DEPTH];

    logic [NUM_PORTS-1:0]    addr_match_s;
    logic [NUM_PORTS-1:0]    arb_excl_s;
    logic [NUM_PORTS-1:0]    arb_mask_s;
    logic [IDX_W-1:0]        start_s;
    logic                    hit_s;
    logic [IDX_W-1:0]        pick_s;
    logic [MEMORY_ADDR_WIDTH-1:0] pick_addr_s;
    logic                    grant_en_s;

    // Round-robin arbiter: first eligible port at or after last_grant+1, wrapping.
    always_comb begin
        addr_match_s = '0;
        arb_excl_s   = '0;
        hit_s        = 1'b0;
        pick_s       = '0;
        pick_addr_s  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            addr_match_s[i] = (req_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH] == addr_r);
        end
        // While responding, the served port and any port waiting on the
        // broadcast word are satisfied by this response and must not re-read.
        if (state_r == RESP) begin
            arb_excl_s = port_onehot(grant_r) | addr_match_s;
        end else begin
            arb_excl_s = '0;
        end
        arb_mask_s = req_valid & ~arb_excl_s;
        if (last_grant_r == LAST_PORT) begin
            start_s = '0;
        end else begin
            start_s = last_grant_r + IDX_W'(1);
        end
        // First pass covers ports from the start pointer upward, second the wrap.
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!hit_s && arb_mask_s[i] && (i >= int'(start_s))) begin
                hit_s       = 1'b1;
                pick_s      = IDX_W'(i);
                pick_addr_s = req_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
            end else begin
                pick_s = pick_s;
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!hit_s && arb_mask_s[i] && (i < int'(start_s))) begin
                hit_s       = 1'b1;
                pick_s      = IDX_W'(i);
                pick_addr_s = req_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
            end else begin
                pick_s = pick_s;
            end
        end
    end

    // Next-state logic; a host write in IDLE or RESP blocks a new grant.
    always_comb begin
        state_nxt_s = state_r;
        grant_en_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (wr_en) begin
                    state_nxt_s = IDLE;
                end else if (hit_s) begin
                    state_nxt_s = READ;
                    grant_en_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                state_nxt_s = RESP;
            end
            RESP: begin
                if (!wr_en && hit_s) begin
                    state_nxt_s = READ;
                    grant_en_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant bookkeeping: latched port, its address, and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_r      <= '0;
            last_grant_r <= LAST_PORT;
            addr_r       <= '0;
        end else if (grant_en_s) begin
            grant_r      <= pick_s;
            last_grant_r <= pick_s;
            addr_r       <= pick_addr_s;
        end
    end

    // Registered read and response outputs; data/address hold between responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready_r       <= '0;
            broadcast_valid_r <= 1'b0;
            rd_data_r         <= '0;
            broadcast_addr_r  <= '0;
        end else if (state_r == READ) begin
            // Same-edge host write lands after this read, giving read-first data.
            req_ready_r       <= port_onehot(grant_r);
            broadcast_valid_r <= 1'b1;
            rd_data_r         <= mem_r[addr_r];
            broadcast_addr_r  <= addr_r;
        end else begin
            req_ready_r       <= '0;
            broadcast_valid_r <= 1'b0;
        end
    end

    // Host write port; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign req_ready       = req_ready_r;
    assign broadcast_valid = broadcast_valid_r;
    assign rd_data         = rd_data_r;
    assign broadcast_addr  = broadcast_addr_r;

endmodule
